// File: rtl/wb_arbiter.sv
// wb_arbiter
// Shares the single ROB write port between the ALU, MEM and MUL result
// streams. Each unit owns a one-entry write-back buffer. A round-robin arbiter
// drains the buffers into the ROB. Every buffer is also exported as a bypass
// source, so a waiting result stays forwardable until it is written.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   flush                      squash all buffered results (mispredict)
//   {alu,mem,mul}_valid/_data/_rob_id   unit result handshake inputs
//   {alu,mem,mul}_ready        buffer can accept a result this cycle
//   rob_wr_en/_data/_id/_src   ROB write port (src 0=ALU 1=MEM 2=MUL)
//   {alu,mem,mul}_wb_data/_wb_rob_id/_wb_bypass_enable   bypass sources
module wb_arbiter #(
    parameter int WORD_SIZE       = 32,
    parameter int ROB_ENTRY_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       alu_valid,
    input  logic [WORD_SIZE-1:0]       alu_data,
    input  logic [ROB_ENTRY_WIDTH-1:0] alu_rob_id,
    output logic                       alu_ready,
    input  logic                       mem_valid,
    input  logic [WORD_SIZE-1:0]       mem_data,
    input  logic [ROB_ENTRY_WIDTH-1:0] mem_rob_id,
    output logic                       mem_ready,
    input  logic                       mul_valid,
    input  logic [WORD_SIZE-1:0]       mul_data,
    input  logic [ROB_ENTRY_WIDTH-1:0] mul_rob_id,
    output logic                       mul_ready,
    output logic                       rob_wr_en,
    output logic [WORD_SIZE-1:0]       rob_wr_data,
    output logic [ROB_ENTRY_WIDTH-1:0] rob_wr_id,
    output logic [1:0]                 rob_wr_src,
    output logic [WORD_SIZE-1:0]       alu_wb_data,
    output logic [ROB_ENTRY_WIDTH-1:0] alu_wb_rob_id,
    output logic                       alu_wb_bypass_enable,
    output logic [WORD_SIZE-1:0]       mem_wb_data,
    output logic [ROB_ENTRY_WIDTH-1:0] mem_wb_rob_id,
    output logic                       mem_wb_bypass_enable,
    output logic [WORD_SIZE-1:0]       mul_wb_data,
    output logic [ROB_ENTRY_WIDTH-1:0] mul_wb_rob_id,
    output logic                       mul_wb_bypass_enable
);

    // Unit index 0=ALU, 1=MEM, 2=MUL throughout.
    logic [2:0]                 in_valid;
    logic [WORD_SIZE-1:0]       in_data [3];
    logic [ROB_ENTRY_WIDTH-1:0] in_id   [3];

    logic [2:0]                 valid_q, valid_d;
    logic [WORD_SIZE-1:0]       data_q  [3];
    logic [WORD_SIZE-1:0]       data_d  [3];
    logic [ROB_ENTRY_WIDTH-1:0] id_q    [3];
    logic [ROB_ENTRY_WIDTH-1:0] id_d    [3];
    logic [1:0]                 rr_q, rr_d;

    logic [1:0]                 gnt_idx;
    logic [2:0]                 grant;
    logic [2:0]                 ready;
    logic                       wr_en;
    logic [WORD_SIZE-1:0]       sel_data;
    logic [ROB_ENTRY_WIDTH-1:0] sel_id;

    assign in_valid   = {mul_valid, mem_valid, alu_valid};
    assign in_data[0] = alu_data;
    assign in_data[1] = mem_data;
    assign in_data[2] = mul_data;
    assign in_id[0]   = alu_rob_id;
    assign in_id[1]   = mem_rob_id;
    assign in_id[2]   = mul_rob_id;

    // Round-robin search starting at rr_q. The last candidate of each order is
    // chosen by elimination; its value is irrelevant when no buffer is valid
    // because wr_en is then low.
    always_comb begin
        gnt_idx = 2'd0;
        case (rr_q)
            2'd1:    gnt_idx = valid_q[1] ? 2'd1 : (valid_q[2] ? 2'd2 : 2'd0);
            2'd2:    gnt_idx = valid_q[2] ? 2'd2 : (valid_q[0] ? 2'd0 : 2'd1);
            default: gnt_idx = valid_q[0] ? 2'd0 : (valid_q[1] ? 2'd1 : 2'd2);
        endcase
    end

    assign wr_en = (|valid_q) && !flush;
    assign grant = wr_en ? (3'b001 << gnt_idx) : 3'b000;
    // A granted buffer empties at this edge, so it can take a new result too.
    assign ready = flush ? 3'b000 : (~valid_q | grant);

    always_comb begin
        sel_data = data_q[0];
        sel_id   = id_q[0];
        case (gnt_idx)
            2'd1: begin
                sel_data = data_q[1];
                sel_id   = id_q[1];
            end
            2'd2: begin
                sel_data = data_q[2];
                sel_id   = id_q[2];
            end
            default: begin
                sel_data = data_q[0];
                sel_id   = id_q[0];
            end
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        rr_d    = rr_q;
        for (int u = 0; u < 3; u++) begin
            data_d[u] = data_q[u];
            id_d[u]   = id_q[u];
        end
        if (flush) begin
            // Flush wins over any capture; ready is already low.
            valid_d = 3'b000;
            rr_d    = 2'd0;
        end else begin
            if (wr_en) begin
                rr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
            end
            for (int u = 0; u < 3; u++) begin
                if (in_valid[u] && ready[u]) begin
                    valid_d[u] = 1'b1;
                    data_d[u]  = in_data[u];
                    id_d[u]    = in_id[u];
                end else if (grant[u]) begin
                    valid_d[u] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 3'b000;
            rr_q    <= 2'd0;
            for (int u = 0; u < 3; u++) begin
                data_q[u] <= '0;
                id_q[u]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rr_q    <= rr_d;
            for (int u = 0; u < 3; u++) begin
                data_q[u] <= data_d[u];
                id_q[u]   <= id_d[u];
            end
        end
    end

    assign alu_ready   = ready[0];
    assign mem_ready   = ready[1];
    assign mul_ready   = ready[2];

    assign rob_wr_en   = wr_en;
    assign rob_wr_data = wr_en ? sel_data : '0;
    assign rob_wr_id   = wr_en ? sel_id   : '0;
    assign rob_wr_src  = wr_en ? gnt_idx  : 2'd0;

    assign alu_wb_data          = data_q[0];
    assign alu_wb_rob_id        = id_q[0];
    assign alu_wb_bypass_enable = valid_q[0];
    assign mem_wb_data          = data_q[1];
    assign mem_wb_rob_id        = id_q[1];
    assign mem_wb_bypass_enable = valid_q[1];
    assign mul_wb_data          = data_q[2];
    assign mul_wb_rob_id        = id_q[2];
    assign mul_wb_bypass_enable = valid_q[2];

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        alu_valid, mem_valid, mul_valid;
    logic [31:0] alu_data, mem_data, mul_data;
    logic [3:0]  alu_rob_id, mem_rob_id, mul_rob_id;
    logic        alu_ready, mem_ready, mul_ready;
    logic        rob_wr_en;
    logic [31:0] rob_wr_data;
    logic [3:0]  rob_wr_id;
    logic [1:0]  rob_wr_src;
    logic [31:0] alu_wb_data, mem_wb_data, mul_wb_data;
    logic [3:0]  alu_wb_rob_id, mem_wb_rob_id, mul_wb_rob_id;
    logic        alu_wb_bypass_enable, mem_wb_bypass_enable, mul_wb_bypass_enable;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.WORD_SIZE(32), .ROB_ENTRY_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alu_valid(alu_valid), .alu_data(alu_data), .alu_rob_id(alu_rob_id), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_data(mem_data), .mem_rob_id(mem_rob_id), .mem_ready(mem_ready),
        .mul_valid(mul_valid), .mul_data(mul_data), .mul_rob_id(mul_rob_id), .mul_ready(mul_ready),
        .rob_wr_en(rob_wr_en), .rob_wr_data(rob_wr_data), .rob_wr_id(rob_wr_id), .rob_wr_src(rob_wr_src),
        .alu_wb_data(alu_wb_data), .alu_wb_rob_id(alu_wb_rob_id), .alu_wb_bypass_enable(alu_wb_bypass_enable),
        .mem_wb_data(mem_wb_data), .mem_wb_rob_id(mem_wb_rob_id), .mem_wb_bypass_enable(mem_wb_bypass_enable),
        .mul_wb_data(mul_wb_data), .mul_wb_rob_id(mul_wb_rob_id), .mul_wb_bypass_enable(mul_wb_bypass_enable)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge of the same cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; mem_valid = 0; mul_valid = 0; flush = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        alu_data = 0; mem_data = 0; mul_data = 0;
        alu_rob_id = 0; mem_rob_id = 0; mul_rob_id = 0;
        next_cycle(); next_cycle();
        reset = 0;
        @(negedge clk);
        vectors++;
        if (rob_wr_en !== 1'b0 || rob_wr_id !== 4'd0 || rob_wr_data !== 32'd0 || rob_wr_src !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: wr_en=%0b id=%0d data=%0h src=%0d, required all 0", rob_wr_en, rob_wr_id, rob_wr_data, rob_wr_src);
        end
        vectors++;
        if ({alu_wb_bypass_enable, mem_wb_bypass_enable, mul_wb_bypass_enable} !== 3'b000 ||
            {alu_ready, mem_ready, mul_ready} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_bypass_ready: byp=%b rdy=%b, required 000/111",
                     {alu_wb_bypass_enable, mem_wb_bypass_enable, mul_wb_bypass_enable}, {alu_ready, mem_ready, mul_ready});
        end
        // Fill all three buffers, drain ALU so rr_ptr moves to 1.
        next_cycle();
        alu_valid = 1; mem_valid = 1; mul_valid = 1;
        alu_rob_id = 4'd11; mem_rob_id = 4'd12; mul_rob_id = 4'd13;
        alu_data = 32'h11; mem_data = 32'h12; mul_data = 32'h13;
        next_cycle();
        idle();
        next_cycle();
        // Two buffers still full here; reset now, mid-cycle.
        reset = 1;
        #2;
        vectors++;
        if (rob_wr_en !== 1'b0 || {alu_wb_bypass_enable, mem_wb_bypass_enable, mul_wb_bypass_enable} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_async: wr_en=%0b byp=%b, required 0/000", rob_wr_en,
                     {alu_wb_bypass_enable, mem_wb_bypass_enable, mul_wb_bypass_enable});
        end
        next_cycle();
        reset = 0;
        // rr_ptr must be 0: with ALU and MUL both waiting, ALU goes first.
        alu_valid = 1; mul_valid = 1; alu_rob_id = 4'd8; mul_rob_id = 4'd9;
        alu_data = 32'h88; mul_data = 32'h99;
        next_cycle();
        idle();
        @(negedge clk);
        vectors++;
        if (rob_wr_en !== 1'b1 || rob_wr_src !== 2'd0 || rob_wr_id !== 4'd8) begin
            miscompares++;
            $display("FAIL reset_rr_ptr: wr_en=%0b src=%0d id=%0d, required 1/0/8", rob_wr_en, rob_wr_src, rob_wr_id);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (rob_wr_en !== 1'b1 || rob_wr_src !== 2'd2 || rob_wr_id !== 4'd9 || rob_wr_data !== 32'h99) begin
            miscompares++;
            $display("FAIL reset_second: wr_en=%0b src=%0d id=%0d data=%0h, required 1/2/9/99", rob_wr_en, rob_wr_src, rob_wr_id, rob_wr_data);
        end
        next_cycle();
    endtask

    task automatic test_three_way();
        logic [3:0] exp_id [3];
        logic [2:0] exp_rdy [3];
        exp_id[0] = 4'd1; exp_id[1] = 4'd2; exp_id[2] = 4'd3;
        // readies {alu,mem,mul} in cycles 1..3
        exp_rdy[0] = 3'b100; exp_rdy[1] = 3'b110; exp_rdy[2] = 3'b111;
        alu_valid = 1; mem_valid = 1; mul_valid = 1;
        alu_rob_id = 4'd1; mem_rob_id = 4'd2; mul_rob_id = 4'd3;
        alu_data = 32'h100; mem_data = 32'h200; mul_data = 32'h300;
        @(negedge clk);
        vectors++;
        if (rob_wr_en !== 1'b0 || {alu_ready, mem_ready, mul_ready} !== 3'b111) begin
            miscompares++;
            $display("FAIL three_cycle0: wr_en=%0b rdy=%b, required 0/111", rob_wr_en, {alu_ready, mem_ready, mul_ready});
        end
        next_cycle();
        idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (rob_wr_en !== 1'b1 || rob_wr_id !== exp_id[c] || rob_wr_src !== 2'(c) ||
                rob_wr_data !== 32'(256 * (c + 1))) begin
                miscompares++;
                $display("FAIL three_write%0d: wr_en=%0b id=%0d src=%0d data=%0h, required 1/%0d/%0d/%0h",
                         c, rob_wr_en, rob_wr_id, rob_wr_src, rob_wr_data, exp_id[c], c, 256 * (c + 1));
            end
            vectors++;
            if ({alu_ready, mem_ready, mul_ready} !== exp_rdy[c]) begin
                miscompares++;
                $display("FAIL three_ready%0d: rdy=%b, required %b", c, {alu_ready, mem_ready, mul_ready}, exp_rdy[c]);
            end
            next_cycle();
        end
        @(negedge clk);
        vectors++;
        if (rob_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL three_idle: wr_en=%0b, required 0", rob_wr_en);
        end
        next_cycle();
    endtask

    task automatic test_single();
        alu_valid = 1; alu_rob_id = 4'd5; alu_data = 32'h0000_1234;
        next_cycle();
        idle();
        @(negedge clk);
        vectors++;
        if (rob_wr_en !== 1'b1 || rob_wr_id !== 4'd5 || rob_wr_data !== 32'h1234 || rob_wr_src !== 2'd0) begin
            miscompares++;
            $display("FAIL single_write: wr_en=%0b id=%0d data=%0h src=%0d, required 1/5/1234/0", rob_wr_en, rob_wr_id, rob_wr_data, rob_wr_src);
        end
        vectors++;
        if (alu_wb_bypass_enable !== 1'b1 || alu_wb_rob_id !== 4'd5 || alu_wb_data !== 32'h1234) begin
            miscompares++;
            $display("FAIL single_bypass: en=%0b id=%0d data=%0h, required 1/5/1234", alu_wb_bypass_enable, alu_wb_rob_id, alu_wb_data);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (alu_wb_bypass_enable !== 1'b0 || rob_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drained: byp=%0b wr_en=%0b, required 0/0", alu_wb_bypass_enable, rob_wr_en);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 9; i++) begin
            alu_valid = (i < 8);
            alu_rob_id = 4'(i); alu_data = 32'hA0 + 32'(i);
            @(negedge clk);
            if (i < 8) begin
                vectors++;
                if (alu_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_ready%0d: alu_ready=%0b, required 1", i, alu_ready);
                end
            end
            if (i > 0) begin
                vectors++;
                if (rob_wr_en !== 1'b1 || rob_wr_id !== 4'(i - 1) || rob_wr_data !== 32'hA0 + 32'(i - 1)) begin
                    miscompares++;
                    $display("FAIL stream_write%0d: wr_en=%0b id=%0d data=%0h, required 1/%0d/%0h",
                             i, rob_wr_en, rob_wr_id, rob_wr_data, i - 1, 32'hA0 + i - 1);
                end
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_flush();
        alu_valid = 1; mem_valid = 1; mul_valid = 1;
        alu_rob_id = 4'd4; mem_rob_id = 4'd5; mul_rob_id = 4'd6;
        next_cycle();
        // Flush cycle, with a competing ALU capture attempt.
        mem_valid = 0; mul_valid = 0;
        alu_valid = 1; alu_rob_id = 4'd7;
        flush = 1;
        @(negedge clk);
        vectors++;
        if (rob_wr_en !== 1'b0 || {alu_ready, mem_ready, mul_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL flush_cycle: wr_en=%0b rdy=%b, required 0/000", rob_wr_en, {alu_ready, mem_ready, mul_ready});
        end
        next_cycle();
        idle();
        @(negedge clk);
        vectors++;
        if ({alu_wb_bypass_enable, mem_wb_bypass_enable, mul_wb_bypass_enable} !== 3'b000 || rob_wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_after: byp=%b wr_en=%0b, required 000/0",
                     {alu_wb_bypass_enable, mem_wb_bypass_enable, mul_wb_bypass_enable}, rob_wr_en);
        end
        next_cycle();
    endtask

    // Runs right after the flush test: rr_ptr was 1 before the flush, so the
    // first grant being ALU also shows the flush reset rr_ptr to 0.
    task automatic test_fairness();
        logic [1:0] exp_src [4];
        exp_src[0] = 2'd0; exp_src[1] = 2'd2; exp_src[2] = 2'd0; exp_src[3] = 2'd2;
        alu_valid = 1; mul_valid = 1;
        alu_rob_id = 4'd10; mul_rob_id = 4'd12;
        alu_data = 32'hAAAA; mul_data = 32'hCCCC;
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (rob_wr_en !== 1'b1 || rob_wr_src !== exp_src[c] ||
                rob_wr_id !== ((exp_src[c] == 2'd0) ? 4'd10 : 4'd12)) begin
                miscompares++;
                $display("FAIL fair_grant%0d: wr_en=%0b src=%0d id=%0d, required src %0d", c, rob_wr_en, rob_wr_src, rob_wr_id, exp_src[c]);
            end
            next_cycle();
        end
        idle();
        for (int c = 0; c < 3; c++) next_cycle();
        @(negedge clk);
        vectors++;
        if (rob_wr_en !== 1'b0 || {alu_wb_bypass_enable, mul_wb_bypass_enable} !== 2'b00) begin
            miscompares++;
            $display("FAIL fair_drain: wr_en=%0b byp=%b, required 0/00", rob_wr_en, {alu_wb_bypass_enable, mul_wb_bypass_enable});
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_three_way();
        test_single();
        test_back_to_back();
        test_flush();
        test_fairness();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
